// File: rtl/step_pkg.sv
// Shared types and constants for the step move planner and its rate timer.
package step_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEL,
        ST_CRUISE,
        ST_DECEL,
        ST_DONE
    } state_t;

    localparam logic [1:0] DIR_FWD = 2'b00;
    localparam logic [1:0] DIR_REV = 2'b01;

    localparam int DEF_START_PERIOD = 400000;
    localparam int DEF_MIN_PERIOD   = 100000;
    localparam int DEF_RAMP_DEC     = 2000;

endpackage

// File: rtl/step_rate_timer.sv
// Loadable down-counter; expire is high for the cycle the enabled count sits at zero.
module step_rate_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q - W'(1);
        end
    end

    assign expire = en && (count_q == '0);

    // rst is active-low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/step_move_planner.sv
// Turns one (steps, direction) move command into a trapezoidal-rate stream of
// step strobes, tracking absolute position and reporting completion or abort.
module step_move_planner
    import step_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int PER_W        = 24,
    parameter int START_PERIOD = DEF_START_PERIOD,
    parameter int MIN_PERIOD   = DEF_MIN_PERIOD,
    parameter int RAMP_DEC     = DEF_RAMP_DEC,
    parameter int POS_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic                    cmd_dir,
    input  logic                    abort,
    output logic                    step_tick,
    output logic [1:0]              dir_out,
    output logic                    motor_en,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [CNT_W-1:0]        steps_remaining,
    output logic signed [POS_W-1:0] position
);

    localparam logic [PER_W-1:0] START_P = PER_W'(START_PERIOD);
    localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PERIOD);
    localparam logic [PER_W:0]   START_X = (PER_W+1)'(START_PERIOD);
    localparam logic [PER_W:0]   MIN_X   = (PER_W+1)'(MIN_PERIOD);
    localparam logic [PER_W:0]   RAMP_X  = (PER_W+1)'(RAMP_DEC);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        remaining_q, remaining_d;
    logic [CNT_W-1:0]        accel_q, accel_d;
    logic [PER_W-1:0]        period_q, period_d;
    logic [1:0]              dir_q, dir_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    aborted_q, aborted_d;

    logic                    moving;
    logic                    tick;
    logic                    timer_load;
    logic [PER_W-1:0]        timer_val;
    logic [CNT_W-1:0]        r_dec;
    logic [CNT_W-1:0]        accel_inc;

    // Period arithmetic is done one bit wider so it saturates instead of wrapping.
    function automatic logic [PER_W-1:0] slower(input logic [PER_W-1:0] p);
        logic [PER_W:0] s;
        s = {1'b0, p} + RAMP_X;
        return (s >= START_X) ? START_P : s[PER_W-1:0];
    endfunction

    function automatic logic [PER_W-1:0] faster(input logic [PER_W-1:0] p);
        return ({1'b0, p} >= (MIN_X + RAMP_X)) ? (p - RAMP_X[PER_W-1:0]) : MIN_P;
    endfunction

    assign moving = (state_q == ST_ACCEL) || (state_q == ST_CRUISE) || (state_q == ST_DECEL);

    step_rate_timer #(
        .W (PER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (moving),
        .expire   (tick)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        accel_d     = accel_q;
        period_d    = period_q;
        dir_d       = dir_q;
        pos_d       = pos_q;
        aborted_d   = aborted_q;
        timer_load  = 1'b0;
        timer_val   = period_q - PER_W'(1);
        r_dec       = remaining_q - CNT_W'(1);
        accel_inc   = (accel_q == '1) ? accel_q : accel_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    remaining_d = cmd_steps;
                    dir_d       = cmd_dir ? DIR_REV : DIR_FWD;
                    aborted_d   = 1'b0;
                    if (cmd_steps == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_ACCEL;
                        period_d   = START_P;
                        accel_d    = '0;
                        timer_load = 1'b1;
                        timer_val  = START_P - PER_W'(1);
                    end
                end
            end
            ST_ACCEL, ST_CRUISE, ST_DECEL: begin
                if (tick) begin
                    remaining_d = r_dec;
                    pos_d       = (dir_q == DIR_REV) ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
                    if (r_dec == '0) begin
                        state_d   = ST_DONE;
                        aborted_d = 1'b0;
                    end else begin
                        case (state_q)
                            ST_ACCEL: begin
                                accel_d = accel_inc;
                                if (r_dec <= accel_inc) begin
                                    state_d = ST_DECEL;
                                end else begin
                                    period_d = faster(period_q);
                                    if (period_d == MIN_P) begin
                                        state_d = ST_CRUISE;
                                    end
                                end
                            end
                            ST_CRUISE: begin
                                if (r_dec <= accel_q) begin
                                    state_d  = ST_DECEL;
                                    period_d = slower(period_q);
                                end
                            end
                            default: begin
                                period_d = slower(period_q);
                            end
                        endcase
                        timer_load = 1'b1;
                        timer_val  = period_d - PER_W'(1);
                    end
                end
                // A tick coinciding with abort has already been accounted above.
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            accel_q     <= '0;
            period_q    <= START_P;
            dir_q       <= DIR_FWD;
            pos_q       <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            accel_q     <= accel_d;
            period_q    <= period_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            aborted_q   <= aborted_d;
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE);
    assign busy            = moving;
    assign motor_en        = moving;
    assign step_tick       = tick;
    assign done            = (state_q == ST_DONE);
    assign aborted         = (state_q == ST_DONE) && aborted_q;
    assign dir_out         = dir_q;
    assign steps_remaining = remaining_q;
    assign position        = pos_q;

endmodule

// File: doc/step_move_planner.md
Name: step_move_planner

Overview:
- Upstream command stage for the full-step motor driver path; turns one move command (step count, direction) into a trapezoidal-rate stream of one-cycle step strobes.
- Also produces a motor enable and a direction code.
- Accepts commands from the host/control logic over a valid/ready handshake.
- Tracks absolute position and reports completion.

Parameters:
- CNT_W, 16, width of step count and remaining-step counter.
- PER_W, 24, width of step-period registers, in clk cycles.
- START_PERIOD, 400000, clk cycles between steps at start and stop (slowest rate).
- MIN_PERIOD, 100000, clk cycles between steps at cruise (fastest rate); must be <= START_PERIOD.
- RAMP_DEC, 2000, period change per step while ramping.
- POS_W, 32, width of the signed absolute position counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  move command present.
- cmd_ready  out  1  planner can accept a command.
- cmd_steps  in  CNT_W  number of full steps to move (unsigned).
- cmd_dir  in  1  0 = forward, 1 = reverse.
- abort  in  1  stop the current move immediately.
- step_tick  out  1  one-cycle strobe; the driver advances one step per strobe.
- dir_out  out  2  direction code to the driver: 2'b00 forward, 2'b01 reverse.
- motor_en  out  1  driver enable.
- busy  out  1  a move is in progress.
- done  out  1  one-cycle pulse when a move ends (normal or aborted).
- aborted  out  1  valid with done; 1 = the move ended by abort.
- steps_remaining  out  CNT_W  steps left in the current move.
- position  out  POS_W  signed absolute position; +1 per forward tick, -1 per reverse tick.

Behaviour:
- Reset (async, rst=0): state IDLE; cmd_ready=1; all other outputs 0; period=START_PERIOD; accel_steps=0.
- States: IDLE, ACCEL, CRUISE, DECEL, DONE.
- cmd_ready=1 only in IDLE.
- busy=1 and motor_en=1 in ACCEL, CRUISE and DECEL.
- done=1 only in DONE; DONE always lasts one cycle, then IDLE.
- Accept: at a clk edge with cmd_valid && cmd_ready, latch steps and dir, and set dir_out.
  - cmd_steps=0 -> go to DONE (aborted=0), no ticks.
  - Otherwise -> go to ACCEL with timer=START_PERIOD-1, period=START_PERIOD, accel_steps=0.
- Timer decrements every cycle while moving. When timer==0, step_tick=1 that cycle and timer reloads to (updated period)-1.
  - First tick occurs exactly START_PERIOD cycles after the accept edge.
- On each tick: remaining r = r-1; position updates. Then, in order:
  - If r==0 -> DONE (aborted=0).
  - ACCEL: accel_steps += 1.
    - If r <= accel_steps -> DECEL, period unchanged.
    - Else period = max(period-RAMP_DEC, MIN_PERIOD); if the result equals MIN_PERIOD -> CRUISE.
  - CRUISE: if r <= accel_steps -> DECEL and period = min(period+RAMP_DEC, START_PERIOD).
  - DECEL: period = min(period+RAMP_DEC, START_PERIOD).
- Period arithmetic saturates and never wraps. accel_steps saturates at its max value.
- Abort while moving -> DONE next cycle with aborted=1; no further ticks.
  - A tick in the same cycle as abort is still issued and counted.
  - steps_remaining holds the unexecuted count.
  - Abort in IDLE or DONE is ignored.
- dir_out and position hold after a move completes.
- cmd_valid outside IDLE is ignored; it is not queued.
- Reset asserted mid-move clears everything immediately. position returns to 0.
- position wraps modulo 2^POS_W.

Decomposition:
- Shared package step_pkg holds:
  - the state enum;
  - the direction code constants DIR_FWD=2'b00 and DIR_REV=2'b01;
  - default period constants.
- One sub-module, step_rate_timer: a loadable down-counter with load value, enable and a one-cycle expire output.

Test Plan:
- Bench parameters: START_PERIOD=10, MIN_PERIOD=4, RAMP_DEC=2.
- 10 forward steps -> tick intervals 10,8,6,4,4,4,4,6,8,10 (64 cycles); position=+10; done pulses the cycle after the last tick with aborted=0.
- 4 reverse steps -> intervals 10,8,8,10; dir_out=2'b01; position=-4; CRUISE never entered.
- cmd_steps=0 -> no ticks; done pulses one cycle after accept; cmd_ready returns next cycle.
- Abort after the 3rd tick of a 10-step move -> no more ticks; done=1 with aborted=1; steps_remaining=7; position=+3.
- cmd_valid held high during a move with a new command -> ignored until IDLE, then accepted with cmd_ready=1.
- rst pulsed low mid-CRUISE -> outputs zero immediately (async); position=0; cmd_ready=1 after release.
